sync_fifo_prog: RTL

Parametrised synchronous FIFO that succeeds the fixed 16-deep UART buffer. It serves as the TX and RX data buffer between the UART bytes and the host interface.
- Depth is any integer ≥ 2, not only a power of two.
- Almost-full and almost-empty thresholds are set at run time through ports.
- Standard or first-word-fall-through (FWFT) read mode is selected by parameter.
- Adds an occupancy output, a synchronous flush, and read-data-valid signalling.

---
 rtl/sync_fifo_prog.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/sync_fifo_prog.sv
// ---------------------------------------------------------------------------
// sync_fifo_prog
//
// Parametrised single-clock FIFO used as the TX/RX byte buffer between the
// UART and the host interface. DEPTH may be any integer >= 2, including
// values that are not a power of two. Almost-full and almost-empty
// thresholds are set at run time. The read mode is chosen by parameter:
// standard registered read (FWFT = 0) or first-word-fall-through (FWFT = 1).
//
// Ports
//   clk          : rising-edge clock for all logic
//   rst_n        : asynchronous active-low reset (clears pointers, count,
//                  dout, dout_valid and the status pulses; storage is kept)
//   flush        : synchronous clear of contents; wins over wr_en and rd_en
//   wr_en, din   : write request and write data
//   rd_en        : read (pop) request
//   dout         : read data
//   dout_valid   : dout holds a valid word
//   full, empty  : occupancy == DEPTH / occupancy == 0
//   almost_full  : count >= af_level
//   almost_empty : count <= ae_level
//   af_level     : almost-full threshold
//   ae_level     : almost-empty threshold
//   count        : current occupancy
//   wr_ack       : one-cycle pulse after an accepted write
//   overflow     : one-cycle pulse after a rejected write
//   underflow    : one-cycle pulse after a rejected read
// ---------------------------------------------------------------------------
module sync_fifo_prog #(
    parameter int DATA_W = 9,
    parameter int DEPTH  = 16,
    parameter int FWFT   = 0,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] din,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    input  logic [CNT_W-1:0]  af_level,
    input  logic [CNT_W-1:0]  ae_level,
    output logic [CNT_W-1:0]  count,
    output logic              wr_ack,
    output logic              overflow,
    output logic              underflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    // Pointer advance with an explicit wrap: DEPTH need not be a power of
    // two, so natural binary rollover would skip or reuse entries.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] n;
        if (p == PTR_LAST) begin
            n = {PTR_W{1'b0}};
        end else begin
            n = p + PTR_W'(1);
        end
        return n;
    endfunction

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  count_nxt_s;
    logic              wr_ack_r;
    logic              overflow_r;
    logic              underflow_r;
    logic              full_s;
    logic              empty_s;
    logic              rd_acc_s;
    logic              wr_acc_s;

    assign full_s  = (count_r == CNT_FULL);
    assign empty_s = (count_r == {CNT_W{1'b0}});

    // Accept decisions. A read at full frees a slot for a same-cycle write;
    // a flush suppresses both so nothing moves on that edge.
    always_comb begin
        rd_acc_s = 1'b0;
        wr_acc_s = 1'b0;
        if (flush) begin
            rd_acc_s = 1'b0;
            wr_acc_s = 1'b0;
        end else begin
            rd_acc_s = rd_en && !empty_s;
            wr_acc_s = wr_en && (!full_s || rd_acc_s);
        end
    end

    // Next occupancy: a simultaneous push and pop leave it unchanged.
    always_comb begin
        count_nxt_s = count_r;
        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= ptr_next(wr_ptr_r);
            end
            if (rd_acc_s) begin
                rd_ptr_r <= ptr_next(rd_ptr_r);
            end
            count_r <= count_nxt_s;
        end
    end

    // Storage array, single write port, intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // One-cycle status pulses describing what happened at the last edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ack_r    <= 1'b0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (flush) begin
            wr_ack_r    <= 1'b0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            wr_ack_r    <= wr_acc_s;
            overflow_r  <= wr_en && !wr_acc_s;
            underflow_r <= rd_en && !rd_acc_s;
        end
    end

    generate
        if (FWFT == 0) begin : g_std
            logic [DATA_W-1:0] dout_r;
            logic              dout_valid_r;

            // Registered read port: data lands one cycle after the pop and
            // is held until the next pop; valid marks that single cycle.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dout_r       <= {DATA_W{1'b0}};
                    dout_valid_r <= 1'b0;
                end else if (flush) begin
                    dout_valid_r <= 1'b0;
                end else begin
                    dout_valid_r <= rd_acc_s;
                    if (rd_acc_s) begin
                        dout_r <= mem_r[rd_ptr_r];
                    end
                end
            end

            assign dout       = dout_r;
            assign dout_valid = dout_valid_r;
        end else begin : g_fwft
            // Head word is always presented; it is meaningful only while
            // the FIFO holds data.
            assign dout       = mem_r[rd_ptr_r];
            assign dout_valid = !empty_s;
        end
    endgenerate

    // A zero af_level and an ae_level >= DEPTH naturally give constant 1.
    assign full         = full_s;
    assign empty        = empty_s;
    assign almost_full  = (count_r >= af_level);
    assign almost_empty = (count_r <= ae_level);
    assign count        = count_r;
    assign wr_ack       = wr_ack_r;
    assign overflow     = overflow_r;
    assign underflow    = underflow_r;

endmodule
